// File: rtl/fg_prog_sequencer.sv
// fg_prog_sequencer
//   Floating-gate programming initiator for one analog island. Accepts one
//   programming command (row/column, pulse count, optional measurement),
//   drives the vertical decoder, drain-select and indirect gate-select lines,
//   applies a counted train of injection pulses, optionally fires a
//   measurement strobe, and returns a status response.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   cmd_valid/ready command handshake (ready only in IDLE)
//   cmd_row/col     target cell row and half (col 0 -> Vg_0/Vsel_0)
//   cmd_pulses      number of injection pulses (0 legal)
//   cmd_measure     issue meas_strobe after the pulse train
//   abort           terminate the active command
//   dec_en/dec_addr decoder enable and address {0, row, col}
//   drain_sel       one-hot drain select (ROWS wide)
//   gate_sel        one-hot indirect-switch gate select
//   inj_pulse       injection pulse enable
//   meas_strobe     one-cycle measurement trigger
//   rsp_*           response handshake and status fields
//   busy            command in progress
module fg_prog_sequencer #(
  parameter int unsigned ROWS       = 10,
  parameter int unsigned ROW_W      = 4,
  parameter int unsigned ADDR_BITS  = 6,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned PULSE_CYC  = 8,
  parameter int unsigned GAP_CYC    = 2,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ROW_W-1:0]     cmd_row,
  input  logic                 cmd_col,
  input  logic [CNT_W-1:0]     cmd_pulses,
  input  logic                 cmd_measure,
  input  logic                 abort,
  output logic                 dec_en,
  output logic [ADDR_BITS-1:0] dec_addr,
  output logic [ROWS-1:0]      drain_sel,
  output logic [1:0]           gate_sel,
  output logic                 inj_pulse,
  output logic                 meas_strobe,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CNT_W-1:0]     rsp_pulses,
  output logic                 rsp_aborted,
  output logic                 rsp_err,
  output logic                 busy
);

  localparam int unsigned TMR_MAX0 = (SETTLE_CYC > PULSE_CYC) ? SETTLE_CYC : PULSE_CYC;
  localparam int unsigned TMR_MAX  = (TMR_MAX0 > GAP_CYC) ? TMR_MAX0 : GAP_CYC;
  localparam int unsigned TMR_W    = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] PULSE_LD  = TMR_W'(PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LD    = TMR_W'(GAP_CYC - 1);
  localparam logic [ROW_W:0]   ROW_LIM   = (ROW_W + 1)'(ROWS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_GAP,
    S_MEAS,
    S_RESP
  } state_e;

  state_e               state_q, state_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic                 col_q, col_d;
  logic [CNT_W-1:0]     pulses_q, pulses_d;
  logic                 measure_q, measure_d;
  logic [CNT_W-1:0]     done_q, done_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic                 aborted_q, aborted_d;
  logic                 err_q, err_d;

  logic                 cmd_ready_q, cmd_ready_d;
  logic                 busy_q, busy_d;
  logic                 dec_en_q, dec_en_d;
  logic [ADDR_BITS-1:0] dec_addr_q, dec_addr_d;
  logic [ROWS-1:0]      drain_sel_q, drain_sel_d;
  logic [1:0]           gate_sel_q, gate_sel_d;
  logic                 inj_pulse_q, inj_pulse_d;
  logic                 meas_strobe_q, meas_strobe_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [CNT_W-1:0]     rsp_pulses_q, rsp_pulses_d;
  logic                 rsp_aborted_q, rsp_aborted_d;
  logic                 rsp_err_q, rsp_err_d;

  logic                 sel_on;
  logic                 in_resp;

  // Next-state logic. Outputs are decoded from the next state and registered,
  // so each output register holds the Moore decode of the state it travels with.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    pulses_d  = pulses_q;
    measure_d = measure_q;
    done_d    = done_q;
    tmr_d     = tmr_q;
    aborted_d = aborted_q;
    err_d     = err_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          row_d     = cmd_row;
          col_d     = cmd_col;
          pulses_d  = cmd_pulses;
          measure_d = cmd_measure;
          done_d    = '0;
          aborted_d = 1'b0;
          if ({1'b0, cmd_row} >= ROW_LIM) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            err_d   = 1'b0;
            tmr_d   = SETTLE_LD;
            state_d = S_SETUP;
          end
        end
      end

      S_SETUP: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_RESP;
        end else if (tmr_q == '0) begin
          if (pulses_q != '0) begin
            tmr_d   = PULSE_LD;
            state_d = S_PULSE;
          end else begin
            state_d = measure_q ? S_MEAS : S_RESP;
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end

      S_PULSE: begin
        // An aborted pulse never reaches its exit, so it is not counted.
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_RESP;
        end else if (tmr_q == '0) begin
          done_d  = done_q + CNT_W'(1);
          tmr_d   = GAP_LD;
          state_d = S_GAP;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end

      S_GAP: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_RESP;
        end else if (tmr_q == '0) begin
          if (done_q < pulses_q) begin
            tmr_d   = PULSE_LD;
            state_d = S_PULSE;
          end else begin
            state_d = measure_q ? S_MEAS : S_RESP;
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end

      S_MEAS: begin
        if (abort) begin
          aborted_d = 1'b1;
        end
        state_d = S_RESP;
      end

      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    sel_on  = (state_d == S_SETUP) || (state_d == S_PULSE) ||
              (state_d == S_GAP)   || (state_d == S_MEAS);
    in_resp = (state_d == S_RESP);

    cmd_ready_d   = (state_d == S_IDLE);
    busy_d        = (state_d != S_IDLE);
    dec_en_d      = sel_on;
    dec_addr_d    = sel_on ? ADDR_BITS'({row_d, col_d}) : '0;
    drain_sel_d   = '0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      drain_sel_d[i] = sel_on && (row_d == ROW_W'(i));
    end
    gate_sel_d    = sel_on ? {col_d, ~col_d} : 2'b00;
    inj_pulse_d   = (state_d == S_PULSE);
    meas_strobe_d = (state_d == S_MEAS);
    rsp_valid_d   = in_resp;
    rsp_pulses_d  = in_resp ? done_d : '0;
    rsp_aborted_d = in_resp && aborted_d;
    rsp_err_d     = in_resp && err_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      row_q         <= '0;
      col_q         <= 1'b0;
      pulses_q      <= '0;
      measure_q     <= 1'b0;
      done_q        <= '0;
      tmr_q         <= '0;
      aborted_q     <= 1'b0;
      err_q         <= 1'b0;
      cmd_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      dec_en_q      <= 1'b0;
      dec_addr_q    <= '0;
      drain_sel_q   <= '0;
      gate_sel_q    <= '0;
      inj_pulse_q   <= 1'b0;
      meas_strobe_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_pulses_q  <= '0;
      rsp_aborted_q <= 1'b0;
      rsp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      pulses_q      <= pulses_d;
      measure_q     <= measure_d;
      done_q        <= done_d;
      tmr_q         <= tmr_d;
      aborted_q     <= aborted_d;
      err_q         <= err_d;
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
      dec_en_q      <= dec_en_d;
      dec_addr_q    <= dec_addr_d;
      drain_sel_q   <= drain_sel_d;
      gate_sel_q    <= gate_sel_d;
      inj_pulse_q   <= inj_pulse_d;
      meas_strobe_q <= meas_strobe_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_pulses_q  <= rsp_pulses_d;
      rsp_aborted_q <= rsp_aborted_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign dec_en      = dec_en_q;
  assign dec_addr    = dec_addr_q;
  assign drain_sel   = drain_sel_q;
  assign gate_sel    = gate_sel_q;
  assign inj_pulse   = inj_pulse_q;
  assign meas_strobe = meas_strobe_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_pulses  = rsp_pulses_q;
  assign rsp_aborted = rsp_aborted_q;
  assign rsp_err     = rsp_err_q;

endmodule
